// File: rtl/if_stage.sv
// Instruction-fetch stage: generates the fetch PC, runs one SRAM-like read at a time
// and holds the fetched {pc, inst} in a single slot for the IF/ID handshake.
module if_stage #(
   parameter int              PC_W     = 32,
   parameter int              INST_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = 32'h1C00_0000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_allowin_i,
   output logic                   if_to_id_valid_o,
   output logic [PC_W+INST_W-1:0] pc_inst_obus,
   input  logic                   br_taken_i,
   input  logic [PC_W-1:0]        br_target_i,
   input  logic                   excp_flush_i,
   input  logic [PC_W-1:0]        excp_pc_i,
   output logic                   inst_sram_req_o,
   output logic [PC_W-1:0]        inst_sram_addr_o,
   input  logic                   inst_sram_addr_ok_i,
   input  logic                   inst_sram_data_ok_i,
   input  logic [INST_W-1:0]      inst_sram_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     seq_pc_q, seq_pc_d;
   logic [PC_W-1:0]     req_addr_q, req_addr_d;
   logic                fs_valid_q, fs_valid_d;
   logic [PC_W-1:0]     fs_pc_q, fs_pc_d;
   logic [INST_W-1:0]   fs_inst_q, fs_inst_d;
   logic                redir_pend_q, redir_pend_d;
   logic [PC_W-1:0]     redir_pc_q, redir_pc_d;
   logic                cancel_q, cancel_d;

   logic                redir_s;
   logic [PC_W-1:0]     redir_tgt_s;
   logic                valid_out_s;
   logic                xfer_s;
   logic                slot_free_s;
   logic                load_s;

   assign redir_s     = excp_flush_i | br_taken_i;
   assign redir_tgt_s = excp_flush_i ? excp_pc_i : br_target_i;
   assign valid_out_s = fs_valid_q & ~redir_s;
   assign xfer_s      = valid_out_s & id_allowin_i;
   assign slot_free_s = ~fs_valid_q | id_allowin_i | redir_s;

   // Fetch FSM, redirect bookkeeping and stage-slot next-state logic.
   always_comb begin
      state_d      = state_q;
      seq_pc_d     = seq_pc_q;
      req_addr_d   = req_addr_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      cancel_d     = cancel_q;
      load_s       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (slot_free_s) begin
               state_d      = S_REQ;
               redir_pend_d = 1'b0;
               // The newest redirect wins over a pending one, which wins over seq_pc.
               if (redir_s) begin
                  req_addr_d = redir_tgt_s;
               end else if (redir_pend_q) begin
                  req_addr_d = redir_pc_q;
               end else begin
                  req_addr_d = seq_pc_q;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REQ: begin
            if (inst_sram_addr_ok_i) begin
               state_d  = S_WAIT;
               seq_pc_d = req_addr_q + PC_W'(4);
            end else begin
               state_d = S_REQ;
            end
         end
         S_WAIT: begin
            if (inst_sram_data_ok_i) begin
               state_d = S_IDLE;
               load_s  = ~cancel_q & ~redir_s;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (redir_s) begin
         redir_pc_d = redir_tgt_s;
         if (state_q != S_IDLE) begin
            redir_pend_d = 1'b1;
         end else begin
            redir_pend_d = 1'b0;
         end
      end else begin
         redir_pc_d = redir_pc_q;
      end

      // A response landing in the redirect cycle is itself the one being dropped,
      // so nothing is left outstanding to cancel.
      if (state_q == S_WAIT && inst_sram_data_ok_i) begin
         cancel_d = 1'b0;
      end else if (redir_s && (state_q == S_REQ || state_q == S_WAIT)) begin
         cancel_d = 1'b1;
      end else begin
         cancel_d = cancel_q;
      end
   end

   // Stage slot: loaded only from a live response, emptied by transfer or redirect.
   always_comb begin
      fs_valid_d = fs_valid_q;
      fs_pc_d    = fs_pc_q;
      fs_inst_d  = fs_inst_q;
      if (load_s) begin
         fs_valid_d = 1'b1;
         fs_pc_d    = req_addr_q;
         fs_inst_d  = inst_sram_rdata_i;
      end else if (redir_s || xfer_s) begin
         fs_valid_d = 1'b0;
      end else begin
         fs_valid_d = fs_valid_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         seq_pc_q     <= RESET_PC;
         req_addr_q   <= '0;
         fs_valid_q   <= 1'b0;
         fs_pc_q      <= '0;
         fs_inst_q    <= '0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= '0;
         cancel_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         seq_pc_q     <= seq_pc_d;
         req_addr_q   <= req_addr_d;
         fs_valid_q   <= fs_valid_d;
         fs_pc_q      <= fs_pc_d;
         fs_inst_q    <= fs_inst_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
         cancel_q     <= cancel_d;
      end
   end

   assign inst_sram_req_o  = (state_q == S_REQ);
   assign inst_sram_addr_o = req_addr_q;
   assign if_to_id_valid_o = valid_out_s;
   assign pc_inst_obus     = {fs_pc_q, fs_inst_q};

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a small SRAM responder plus queues of expected
// request addresses and expected {pc, inst} deliveries to ID.
module tb_if_stage;

   localparam logic [31:0] RST_PC = 32'h1C00_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_allowin_i;
   logic        if_to_id_valid_o;
   logic [63:0] pc_inst_obus;
   logic        br_taken_i;
   logic [31:0] br_target_i;
   logic        excp_flush_i;
   logic [31:0] excp_pc_i;
   logic        inst_sram_req_o;
   logic [31:0] inst_sram_addr_o;
   logic        inst_sram_addr_ok_i;
   logic        inst_sram_data_ok_i;
   logic [31:0] inst_sram_rdata_i;

   if_stage #(.PC_W(32), .INST_W(32), .RESET_PC(RST_PC)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .id_allowin_i        (id_allowin_i),
      .if_to_id_valid_o    (if_to_id_valid_o),
      .pc_inst_obus        (pc_inst_obus),
      .br_taken_i          (br_taken_i),
      .br_target_i         (br_target_i),
      .excp_flush_i        (excp_flush_i),
      .excp_pc_i           (excp_pc_i),
      .inst_sram_req_o     (inst_sram_req_o),
      .inst_sram_addr_o    (inst_sram_addr_o),
      .inst_sram_addr_ok_i (inst_sram_addr_ok_i),
      .inst_sram_data_ok_i (inst_sram_data_ok_i),
      .inst_sram_rdata_i   (inst_sram_rdata_i)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_req_q[$];
   logic [63:0] exp_slot_q[$];

   // SRAM responder state
   logic        pend_v    = 1'b0;
   logic [31:0] pend_a    = 32'h0;
   logic        acc_seen  = 1'b0;
   logic [31:0] acc_addr  = 32'h0;
   logic        dok_seen  = 1'b0;
   int          wcnt      = 0;
   int          delay     = 0;
   int          stale_cnt = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == RST_PC) ? 32'h0280_0400 : (a ^ 32'h5A5A_A5A5);
   endfunction

   function automatic logic [63:0] slot_of(input logic [31:0] a);
      return {a, mem(a)};
   endfunction

   // One clock: update the SRAM model just after the edge, apply controls,
   // then score requests and deliveries at the falling edge.
   task automatic step(input logic allow, input logic br, input logic [31:0] brt,
                       input logic ex, input logic [31:0] ext);
      logic [31:0] e32;
      logic [63:0] e64;
      @(posedge clk);
      #1;
      if (dok_seen) pend_v = 1'b0;
      if (acc_seen) begin
         pend_v = 1'b1;
         pend_a = acc_addr;
      end
      if (!rst_n) begin
         pend_v = 1'b0;
         wcnt   = 0;
      end
      inst_sram_data_ok_i = pend_v | (stale_cnt != 0);
      inst_sram_rdata_i   = pend_v ? mem(pend_a) : 32'hDEAD_BEEF;
      if (stale_cnt != 0) stale_cnt--;
      inst_sram_addr_ok_i = rst_n & inst_sram_req_o & (wcnt >= delay);
      id_allowin_i = allow;
      br_taken_i   = br;
      br_target_i  = brt;
      excp_flush_i = ex;
      excp_pc_i    = ext;
      @(negedge clk);
      dok_seen = inst_sram_data_ok_i;
      acc_seen = 1'b0;
      if (inst_sram_req_o && inst_sram_addr_ok_i) begin
         e32 = (exp_req_q.size() > 0) ? exp_req_q.pop_front() : 32'hFFFF_FFFF;
         check_val("req_addr", {32'h0, inst_sram_addr_o}, {32'h0, e32});
         acc_seen = 1'b1;
         acc_addr = inst_sram_addr_o;
         wcnt     = 0;
      end else if (inst_sram_req_o) begin
         wcnt++;
      end
      if (if_to_id_valid_o && id_allowin_i) begin
         e64 = (exp_slot_q.size() > 0) ? exp_slot_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
         check_val("slot_to_id", pc_inst_obus, e64);
      end
   endtask

   task automatic idle_step(input logic allow);
      step(allow, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20; i++) begin
         if (if_to_id_valid_o) break;
         idle_step(1'b0);
      end
      check_val("wait_valid", {63'h0, if_to_id_valid_o}, 64'h1);
   endtask

   task automatic check_reset_outs(input string tag);
      check_val({tag, "_req"},   {63'h0, inst_sram_req_o}, 64'h0);
      check_val({tag, "_addr"},  {32'h0, inst_sram_addr_o}, 64'h0);
      check_val({tag, "_valid"}, {63'h0, if_to_id_valid_o}, 64'h0);
      check_val({tag, "_obus"},  pc_inst_obus, 64'h0);
   endtask

   initial begin
      int held;
      rst_n = 1'b0;
      id_allowin_i = 1'b0;
      br_taken_i = 1'b0;
      br_target_i = 32'h0;
      excp_flush_i = 1'b0;
      excp_pc_i = 32'h0;
      inst_sram_addr_ok_i = 1'b0;
      inst_sram_data_ok_i = 1'b0;
      inst_sram_rdata_i = 32'h0;
      #1;
      check_reset_outs("reset");
      idle_step(1'b0);
      idle_step(1'b0);
      rst_n = 1'b1;

      // First fetch, then ID stalls with the slot full.
      exp_req_q.push_back(RST_PC);
      exp_req_q.push_back(RST_PC + 32'd4);
      exp_slot_q.push_back(slot_of(RST_PC));
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         idle_step(1'b0);
         check_val("stall_req",   {63'h0, inst_sram_req_o}, 64'h0);
         check_val("stall_valid", {63'h0, if_to_id_valid_o}, 64'h1);
         check_val("stall_obus",  pc_inst_obus, {RST_PC, 32'h0280_0400});
      end
      idle_step(1'b1);
      check_val("xfer_req_low", {63'h0, inst_sram_req_o}, 64'h0);
      idle_step(1'b1);
      check_val("resume_req", {63'h0, inst_sram_req_o}, 64'h1);

      // Branch while the 0x1C000004 fetch is in WAIT: its data is dropped.
      step(1'b1, 1'b1, 32'h1C00_0100, 1'b0, 32'h0);
      check_val("br_valid", {63'h0, if_to_id_valid_o}, 64'h0);
      exp_req_q.push_back(32'h1C00_0100);
      exp_req_q.push_back(32'h1C00_0104);
      exp_slot_q.push_back(slot_of(32'h1C00_0100));
      wait_valid();
      idle_step(1'b1);
      wait_valid();

      // Exception and branch together with a valid slot: exception target wins.
      step(1'b1, 1'b1, 32'h1C00_0300, 1'b1, 32'h1C00_8000);
      check_val("flush_valid", {63'h0, if_to_id_valid_o}, 64'h0);
      exp_req_q.push_back(32'h1C00_8000);
      exp_slot_q.push_back(slot_of(32'h1C00_8000));
      wait_valid();
      idle_step(1'b1);

      // Redirect while the request waits three cycles for addr_ok.
      delay = 3;
      exp_req_q.push_back(32'h1C00_8004);
      step(1'b1, 1'b1, 32'h1C00_0200, 1'b0, 32'h0);
      check_val("hold_req0",  {63'h0, inst_sram_req_o}, 64'h1);
      check_val("hold_addr0", {32'h0, inst_sram_addr_o}, {32'h0, 32'h1C00_8004});
      held = 0;
      for (int i = 0; i < 10; i++) begin
         idle_step(1'b1);
         held++;
         check_val("hold_req",  {63'h0, inst_sram_req_o}, 64'h1);
         check_val("hold_addr", {32'h0, inst_sram_addr_o}, {32'h0, 32'h1C00_8004});
         if (acc_seen) break;
      end
      check_val("hold_cycles", 64'(held), 64'd3);
      delay = 0;
      exp_req_q.push_back(32'h1C00_0200);
      exp_slot_q.push_back(slot_of(32'h1C00_0200));
      wait_valid();
      idle_step(1'b1);

      // Reset while in WAIT, with stale data_ok around the release.
      exp_req_q.push_back(32'h1C00_0204);
      idle_step(1'b1);
      idle_step(1'b0);
      #1;
      rst_n = 1'b0;
      stale_cnt = 3;
      #1;
      check_reset_outs("midrst");
      idle_step(1'b0);
      idle_step(1'b0);
      rst_n = 1'b1;
      exp_req_q.push_back(RST_PC);
      exp_slot_q.push_back(slot_of(RST_PC));
      wait_valid();
      idle_step(1'b1);

      check_val("req_q_empty",  64'(exp_req_q.size()), 64'd0);
      check_val("slot_q_empty", 64'(exp_slot_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
